// File: rtl/branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
//
// Execute-stage branch/jump resolution and owner of the fetch PC.
// Each cycle the comparator result and decoded control-flow flags decide
// taken/not-taken. A taken, aligned transfer redirects pc_if, pulses flush_ex
// for one cycle and spends one BUBBLE cycle with fetch_req low. A taken
// transfer to a misaligned target raises exc_misalign and parks in TRAP
// until trap_clr restarts fetch at trap_vec.
//
// Build option:
//   BRANCH_RVC_ALIGN_EN  defined   -> targets need only 16-bit alignment
//                        undefined -> targets need 32-bit alignment
//   The sequential fetch increment is +4 in both builds.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   valid_de          execute holds a valid instruction
//   is_branch_de      conditional branch
//   is_jal_de         JAL
//   is_jalr_de        JALR
//   jump_state_pre    comparator result (1 = condition true)
//   pc_de             PC of the execute instruction
//   imm_de            sign-extended immediate
//   rs1data_de        JALR base operand
//   fetch_ack         fetch accepted pc_if this cycle
//   trap_clr          leave TRAP
//   trap_vec          restart PC on trap_clr
//   pc_if             registered fetch PC
//   fetch_req         fetch request (high only in RUN)
//   flush_ex          one-cycle squash of younger instructions
//   link_ex           pc_de+4 of the last taken JAL/JALR
//   exc_misalign      misaligned-target trap pending
//   exc_pc            PC of the faulting jump
// ----------------------------------------------------------------------------
module branch_resolve #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_VECT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_de,
  input  logic            is_branch_de,
  input  logic            is_jal_de,
  input  logic            is_jalr_de,
  input  logic            jump_state_pre,
  input  logic [XLEN-1:0] pc_de,
  input  logic [XLEN-1:0] imm_de,
  input  logic [XLEN-1:0] rs1data_de,
  input  logic            fetch_ack,
  input  logic            trap_clr,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc_if,
  output logic            fetch_req,
  output logic            flush_ex,
  output logic [XLEN-1:0] link_ex,
  output logic            exc_misalign,
  output logic [XLEN-1:0] exc_pc
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    TRAP   = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  state_t          state;
  logic            taken_p0;
  logic            is_link_p0;
  logic            misaligned_p0;
  logic [XLEN-1:0] jalr_sum_p0;
  logic [XLEN-1:0] target_p0;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
`ifdef BRANCH_RVC_ALIGN_EN
    return addr[0];
`else
    return |addr[1:0];
`endif
  endfunction

  // Stage p0: combinational decision on the current execute instruction
  always_comb begin
    taken_p0      = valid_de & (is_jal_de | is_jalr_de | (is_branch_de & jump_state_pre));
    is_link_p0    = is_jal_de | is_jalr_de;
    jalr_sum_p0   = rs1data_de + imm_de;
    target_p0     = pc_de + imm_de;
    if (is_jalr_de) begin
      target_p0 = {jalr_sum_p0[XLEN-1:1], 1'b0};
    end
    misaligned_p0 = is_misaligned(target_p0);
  end

  // Stage p1: all architectural effects registered at the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      pc_if        <= RESET_VECT;
      fetch_req    <= 1'b1;
      flush_ex     <= 1'b0;
      link_ex      <= '0;
      exc_misalign <= 1'b0;
      exc_pc       <= '0;
    end else begin
      flush_ex <= 1'b0;
      case (state)
        RUN: begin
          if (taken_p0) begin
            // A redirect or trap takes priority over a same-edge fetch_ack.
            flush_ex  <= 1'b1;
            fetch_req <= 1'b0;
            if (is_link_p0) begin
              link_ex <= pc_de + INSN_BYTES;
            end
            if (misaligned_p0) begin
              exc_misalign <= 1'b1;
              exc_pc       <= pc_de;
              state        <= TRAP;
            end else begin
              pc_if <= target_p0;
              state <= BUBBLE;
            end
          end else if (fetch_ack) begin
            pc_if <= pc_if + INSN_BYTES;
          end
        end
        BUBBLE: begin
          fetch_req <= 1'b1;
          state     <= RUN;
        end
        TRAP: begin
          if (trap_clr) begin
            pc_if        <= trap_vec;
            exc_misalign <= 1'b0;
            fetch_req    <= 1'b1;
            state        <= RUN;
          end
        end
        default: begin
          fetch_req <= 1'b1;
          state     <= RUN;
        end
      endcase
    end
  end

endmodule
